// File: rtl/mm_line_burst_writer_if.sv
// FIFO read side plus AXI4 write-channel bundle for the line burst writer.
// master = the writer, slave = FIFO/interconnect side.
interface mm_line_burst_writer_if #(
  parameter int ASIZE          = 29,
  parameter int AXI_DSIZE      = 256,
  parameter int IDSIZE         = 4,
  parameter int BURST_LEN_SIZE = 8,
  parameter int CSIZE          = 10
);
  logic [CSIZE-1:0]          fifo_count;
  logic [AXI_DSIZE-1:0]      fifo_dout;
  logic                      fifo_rd_en;
  logic [IDSIZE-1:0]         axi_awid;
  logic [ASIZE-1:0]          axi_awaddr;
  logic [BURST_LEN_SIZE-1:0] axi_awlen;
  logic [2:0]                axi_awsize;
  logic [1:0]                axi_awburst;
  logic                      axi_awvalid;
  logic                      axi_awready;
  logic [AXI_DSIZE-1:0]      axi_wdata;
  logic [AXI_DSIZE/8-1:0]    axi_wstrb;
  logic                      axi_wlast;
  logic                      axi_wvalid;
  logic                      axi_wready;
  logic                      axi_bready;
  logic [IDSIZE-1:0]         axi_bid;
  logic [1:0]                axi_bresp;
  logic                      axi_bvalid;

  modport master (
    input  fifo_count, fifo_dout, axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
    output fifo_rd_en, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
           axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready
  );

  modport slave (
    output fifo_count, fifo_dout, axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid,
    input  fifo_rd_en, axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
           axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready
  );
endinterface

// File: rtl/mm_line_burst_writer.sv
// AXI4 write master: moves one video line per request from the show-ahead FIFO
// into memory as bursts capped by MAX_BURST and 4 KB pages, MAX_OUTSTANDING deep.
module mm_line_burst_writer #(
  parameter int ASIZE           = 29,
  parameter int AXI_DSIZE       = 256,
  parameter int IDSIZE          = 4,
  parameter int ID              = 0,
  parameter int BURST_LEN_SIZE  = 8,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CSIZE           = 10
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [ASIZE-1:0] cfg_base_addr,
  input  logic [ASIZE-1:0] cfg_line_stride,
  input  logic [15:0]      cfg_line_beats,
  input  logic             frame_start,
  input  logic             line_req,
  output logic             line_ack,
  output logic             line_done,
  output logic             busy,
  output logic             err_flag,
  mm_line_burst_writer_if.master bus
);
  localparam int BB     = AXI_DSIZE / 8;
  localparam int BB_LOG = $clog2(BB);
  localparam int LW     = $clog2(MAX_BURST + 1);
  localparam int OW     = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_WAITDATA, S_AW, S_W, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [ASIZE-1:0]          line_ptr_q, line_ptr_d;
  logic [ASIZE-1:0]          addr_q, addr_d;
  logic [ASIZE-1:0]          awaddr_q, awaddr_d;
  logic [15:0]               remaining_q, remaining_d;
  logic [LW-1:0]             len_q, len_d;
  logic [LW-1:0]             beat_q, beat_d;
  logic [BURST_LEN_SIZE-1:0] awlen_q, awlen_d;
  logic [OW-1:0]             outst_q, outst_d;
  logic pending_q, pending_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic line_ack_q, line_ack_d, line_done_q, line_done_d, busy_q, busy_d, err_q, err_d;

  logic             aw_hs, w_hs, b_hs;
  logic [ASIZE-1:0] ptr_eff;
  logic [12:0]      to_4k;
  logic [16:0]      cap;
  logic [LW-1:0]    burst_len;
  logic             unused_bid;

  assign aw_hs = awvalid_q & bus.axi_awready;
  assign w_hs  = wvalid_q & bus.axi_wready;
  // A stray B with nothing outstanding must not wrap the counter.
  assign b_hs  = bus.axi_bvalid & ((outst_q != '0) | aw_hs);
  assign unused_bid = ^bus.axi_bid;

  // Next burst length: remaining beats, burst cap and beats left in the 4 KB page.
  always_comb begin
    to_4k = (13'h1000 - {1'b0, addr_q[11:0]}) >> BB_LOG;
    cap   = {1'b0, remaining_q};
    if (cap > 17'(MAX_BURST)) cap = 17'(MAX_BURST);
    if (cap > 17'(to_4k))     cap = 17'(to_4k);
    burst_len = LW'(cap);
  end

  always_comb begin
    state_d     = state_q;
    line_ptr_d  = line_ptr_q;
    addr_d      = addr_q;
    awaddr_d    = awaddr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    beat_d      = beat_q;
    awlen_d     = awlen_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    busy_d      = busy_q;
    line_ack_d  = 1'b0;
    line_done_d = 1'b0;
    ptr_eff     = (pending_q | frame_start) ? cfg_base_addr : line_ptr_q;
    pending_d   = pending_q | (frame_start & busy_q);
    err_d       = err_q | (bus.axi_bvalid & (bus.axi_bresp != 2'b00));

    case ({aw_hs, b_hs})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IDLE: begin
        line_ptr_d = ptr_eff;
        pending_d  = 1'b0;
        if (line_req) begin
          remaining_d = cfg_line_beats;
          addr_d      = ptr_eff;
          line_ack_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        len_d   = burst_len;
        state_d = S_WAITDATA;
      end
      S_WAITDATA: begin
        if ((32'(bus.fifo_count) >= 32'(len_q)) && (outst_q < OW'(MAX_OUTSTANDING))) begin
          awvalid_d = 1'b1;
          awaddr_d  = addr_q;
          awlen_d   = BURST_LEN_SIZE'(len_q - LW'(1));
          state_d   = S_AW;
        end
      end
      S_AW: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = (len_q == LW'(1));
          beat_d    = '0;
          state_d   = S_W;
        end
      end
      S_W: begin
        if (w_hs) begin
          if (wlast_q) begin
            wvalid_d    = 1'b0;
            wlast_d     = 1'b0;
            addr_d      = addr_q + (ASIZE'(len_q) << BB_LOG);
            remaining_d = remaining_q - 16'(len_q);
            state_d     = (remaining_q == 16'(len_q)) ? S_DRAIN : S_CALC;
          end else begin
            beat_d  = beat_q + LW'(1);
            wlast_d = ((LW+1)'(beat_q) + (LW+1)'(2)) == (LW+1)'(len_q);
          end
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) begin
          line_done_d = 1'b1;
          busy_d      = 1'b0;
          line_ptr_d  = line_ptr_q + cfg_line_stride;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      line_ptr_q  <= '0;
      addr_q      <= '0;
      awaddr_q    <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      awlen_q     <= '0;
      outst_q     <= '0;
      pending_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      line_ack_q  <= 1'b0;
      line_done_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_ptr_q  <= line_ptr_d;
      addr_q      <= addr_d;
      awaddr_q    <= awaddr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      awlen_q     <= awlen_d;
      outst_q     <= outst_d;
      pending_q   <= pending_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      line_ack_q  <= line_ack_d;
      line_done_q <= line_done_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign line_ack    = line_ack_q;
  assign line_done   = line_done_q;
  assign busy        = busy_q;
  assign err_flag    = err_q;

  assign bus.axi_awid    = IDSIZE'(ID);
  assign bus.axi_awaddr  = awaddr_q;
  assign bus.axi_awlen   = awlen_q;
  assign bus.axi_awsize  = 3'(BB_LOG);
  assign bus.axi_awburst = 2'b01;
  assign bus.axi_awvalid = awvalid_q;
  assign bus.axi_wdata   = bus.fifo_dout;
  assign bus.axi_wstrb   = '1;
  assign bus.axi_wlast   = wlast_q;
  assign bus.axi_wvalid  = wvalid_q;
  assign bus.axi_bready  = 1'b1;
  assign bus.fifo_rd_en  = w_hs;
endmodule

// File: tb/tb_mm_line_burst_writer.sv
// Randomised bench for mm_line_burst_writer: a burst-list model derived from the
// line/4K/MAX_BURST rules is compared against every AW, W and B event.
module tb_mm_line_burst_writer;
  localparam int ASIZE = 29, DW = 256, BB = 32, MAXB = 64, MAXO = 4;
  localparam int unsigned AMASK = 32'h1FFF_FFFF;

  typedef struct {int unsigned addr; int unsigned len; int line;} burst_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic [ASIZE-1:0] cfg_base_addr, cfg_line_stride;
  logic [15:0] cfg_line_beats;
  logic frame_start, line_req, line_ack, line_done, busy, err_flag;

  mm_line_burst_writer_if #(.ASIZE(ASIZE), .AXI_DSIZE(DW), .IDSIZE(4), .BURST_LEN_SIZE(8), .CSIZE(10)) bus ();

  mm_line_burst_writer #(
    .ASIZE(ASIZE), .AXI_DSIZE(DW), .IDSIZE(4), .ID(0), .BURST_LEN_SIZE(8),
    .MAX_BURST(MAXB), .MAX_OUTSTANDING(MAXO), .CSIZE(10)
  ) dut (
    .clock(clock), .rst(rst), .cfg_base_addr(cfg_base_addr), .cfg_line_stride(cfg_line_stride),
    .cfg_line_beats(cfg_line_beats), .frame_start(frame_start), .line_req(line_req),
    .line_ack(line_ack), .line_done(line_done), .busy(busy), .err_flag(err_flag), .bus(bus)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0, total_cnt = 0;
  burst_t exp_aw[$];
  burst_t plan[$];
  int w_lens[$];
  int line_seq = 0, done_line = 0;
  int unsigned mdl_ptr = 0;
  int aw_total = 0, b_issued = 0, b_limit = 1 << 30, err_idx = -1;
  int outstanding_m = 0, beat_m = 0;
  bit model_err = 0, rdy_rand = 0, aw_man = 1, w_man = 1;
  bit prev_stall = 0;
  logic [ASIZE-1:0] prev_awaddr;
  logic [7:0] prev_awlen;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Expected burst list for one line, straight from the splitting rules.
  task automatic plan_line(input int unsigned a, input int unsigned beats);
    int unsigned rem, l, to4k;
    plan.delete();
    rem = beats;
    while (rem > 0) begin
      to4k = (4096 - (a % 4096)) / BB;
      l = rem;
      if (l > MAXB) l = MAXB;
      if (l > to4k) l = to4k;
      plan.push_back('{a, l, line_seq});
      a = (a + l * BB) & AMASK;
      rem -= l;
    end
  endtask

  task automatic commit_plan();
    foreach (plan[i]) exp_aw.push_back('{plan[i].addr, plan[i].len, line_seq});
    line_seq++;
  endtask

  // Stimulus driver (posedge+1) and compare process (negedge) for the AXI/FIFO side.
  initial begin : bg
    bus.fifo_count = 10'd1023;
    bus.fifo_dout = '0; bus.axi_awready = 0; bus.axi_wready = 0;
    bus.axi_bvalid = 0; bus.axi_bresp = 0; bus.axi_bid = 0;
    forever begin
      @(posedge clock); #1;
      bus.fifo_dout = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (rdy_rand) begin
        bus.axi_awready = ($urandom % 4) != 0;
        bus.axi_wready  = ($urandom % 4) != 0;
      end else begin
        bus.axi_awready = aw_man;
        bus.axi_wready  = w_man;
      end
      if (!rst && b_issued < aw_total && b_issued < b_limit && (!rdy_rand || ($urandom % 3) != 0)) begin
        bus.axi_bvalid = 1;
        bus.axi_bresp  = (b_issued == err_idx) ? 2'd2 : 2'd0;
        b_issued++;
      end else begin
        bus.axi_bvalid = 0;
        bus.axi_bresp  = 2'($urandom);
      end
      bus.axi_bid = 4'($urandom);

      @(negedge clock);
      if (rst) begin
        exp_aw.delete(); w_lens.delete();
        outstanding_m = 0; beat_m = 0; model_err = 0; aw_total = 0; b_issued = 0;
        done_line = 0; prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("aw_stable_addr", bus.axi_awaddr, prev_awaddr);
          chk("aw_stable_len", bus.axi_awlen, prev_awlen);
          chk("aw_stable_valid", bus.axi_awvalid, 1);
        end
        prev_stall  = bus.axi_awvalid && !bus.axi_awready;
        prev_awaddr = bus.axi_awaddr;
        prev_awlen  = bus.axi_awlen;
        if (line_done) begin
          chk("done_outstanding", outstanding_m, 0);
          chk("done_w_pending", w_lens.size(), 0);
          if (exp_aw.size() > 0) chk("done_bursts_issued", exp_aw[0].line > done_line, 1);
          done_line++;
        end
        if (bus.axi_awvalid && bus.axi_awready) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
          else begin
            burst_t b;
            b = exp_aw.pop_front();
            chk("awaddr", bus.axi_awaddr, b.addr);
            chk("awlen", bus.axi_awlen, b.len - 1);
            w_lens.push_back(b.len);
          end
          chk("aw_outstanding_cap", outstanding_m < MAXO, 1);
          chk("aw_const", {bus.axi_awid, bus.axi_awsize, bus.axi_awburst}, {4'd0, 3'd5, 2'd1});
          outstanding_m++;
          aw_total++;
        end
        if (bus.axi_wvalid) chk("fifo_rd_en", bus.fifo_rd_en, bus.axi_wready);
        if (bus.axi_wvalid && bus.axi_wready) begin
          if (w_lens.size() == 0) chk("w_unexpected", 1, 0);
          else begin
            chk("wdata", bus.axi_wdata, bus.fifo_dout);
            chk("wlast", bus.axi_wlast, beat_m == w_lens[0] - 1);
            beat_m++;
            if (beat_m == w_lens[0]) begin void'(w_lens.pop_front()); beat_m = 0; end
          end
        end
        if (bus.axi_bvalid) outstanding_m--;
        chk("err_flag", err_flag, model_err);
        if (bus.axi_bvalid && bus.axi_bresp != 0) model_err = 1;
      end
    end
  end

  task automatic new_frame(input int unsigned base);
    @(posedge clock); #1;
    cfg_base_addr = base[ASIZE-1:0];
    frame_start = 1;
    @(posedge clock); #1;
    frame_start = 0;
    mdl_ptr = base & AMASK;
  endtask

  task automatic start_line(input int beats);
    int n;
    cfg_line_beats = 16'(beats);
    plan_line(mdl_ptr, beats);
    commit_plan();
    @(posedge clock); #1;
    line_req = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!line_ack && n < 50);
    chk("ack_latency", n, 2);
    chk("ack_busy", busy, 1);
    chk("ack_no_aw", bus.axi_awvalid, 0);
    @(posedge clock); #1;
    line_req = 0;
    @(negedge clock);
    chk("aw_not_early", bus.axi_awvalid, 0);
  endtask

  task automatic finish_line();
    int n;
    n = 0;
    while (!line_done && n < 20000) begin @(negedge clock); n++; end
    chk("line_done_seen", line_done, 1);
    chk("done_busy_low", busy, 0);
    mdl_ptr = (mdl_ptr + cfg_line_stride) & AMASK;
  endtask

  task automatic run_line(input int beats);
    start_line(beats);
    finish_line();
  endtask

  initial begin : main
    int n, done_at;
    bit saw;
    int base_aw;
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : test
    int n, done_at, base_aw;
    bit saw;
    cfg_base_addr = '0; cfg_line_stride = 29'h2000; cfg_line_beats = 16'd1;
    frame_start = 0; line_req = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_awvalid", bus.axi_awvalid, 0);
    chk("rst_wvalid", bus.axi_wvalid, 0);
    chk("rst_wlast", bus.axi_wlast, 0);
    chk("rst_bready", bus.axi_bready, 1);
    chk("rst_awconst", {bus.axi_awid, bus.axi_awsize, bus.axi_awburst}, {4'd0, 3'd5, 2'd1});
    chk("rst_awaddr_len", {bus.axi_awaddr, bus.axi_awlen}, 0);
    chk("rst_ctrl", {line_ack, line_done, busy, err_flag, bus.fifo_rd_en}, 0);
    chk("rst_wstrb", bus.axi_wstrb, 32'hFFFF_FFFF);
    @(posedge clock); #1;
    rst = 0;

    // Pin the model against hand-computed burst splits.
    plan_line(0, 100);
    chk("model_split_n", plan.size(), 2);
    chk("model_b0", {plan[0].addr, plan[0].len}, {32'h0, 32'd64});
    chk("model_b1", {plan[1].addr, plan[1].len}, {32'h800, 32'd36});
    plan_line(32'hF80, 10);
    chk("model_4k_n", plan.size(), 2);
    chk("model_4k_b0", {plan[0].addr, plan[0].len}, {32'hF80, 32'd4});
    chk("model_4k_b1", {plan[1].addr, plan[1].len}, {32'h1000, 32'd6});

    // Plain line, then a line straddling a 4 KB page.
    new_frame(0); run_line(100);
    new_frame(32'hF80); run_line(10);

    // Three lines with line_req held high; frame restart requested during line 2.
    new_frame(0);
    cfg_line_beats = 16'd40;
    plan_line(0, 40); commit_plan();
    plan_line(32'h2000, 40); commit_plan();
    plan_line(0, 40); commit_plan();
    @(posedge clock); #1;
    line_req = 1;
    for (int k = 0; k < 3; k++) begin
      n = 0; done_at = -100;
      do begin
        @(negedge clock); n++;
        if (line_done) done_at = n;
      end while (!line_ack && n < 3000);
      chk("held_ack_seen", line_ack, 1);
      if (k > 0) chk("held_gap", n - done_at, 1);
      if (k == 1) begin
        @(posedge clock); #1; frame_start = 1;
        @(posedge clock); #1; frame_start = 0;
      end
      if (k == 2) begin @(posedge clock); #1; line_req = 0; end
    end
    mdl_ptr = 0;
    finish_line();

    // Outstanding cap with B channel held off.
    new_frame(0);
    base_aw = aw_total;
    b_limit = b_issued;
    start_line(640);
    repeat (400) @(negedge clock);
    chk("cap_aw_count", aw_total - base_aw, 4);
    chk("cap_aw_idle", bus.axi_awvalid, 0);
    b_limit = b_limit + 1;
    n = 0;
    while (aw_total - base_aw < 5 && n < 50) begin @(negedge clock); n++; end
    chk("cap_aw_after_b", aw_total - base_aw, 5);
    b_limit = 1 << 30;
    finish_line();

    // FIFO starvation, then an AW stall.
    new_frame(32'h10000);
    bus.fifo_count = 10'd10;
    aw_man = 0;
    start_line(64);
    saw = 0;
    repeat (50) begin @(negedge clock); if (bus.axi_awvalid) saw = 1; end
    chk("starve_no_aw", saw, 0);
    @(posedge clock); #1;
    bus.fifo_count = 10'd64;
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.axi_awvalid && n < 10);
    chk("starve_resume", n <= 2, 1);
    repeat (7) begin
      chk("stall_awaddr", bus.axi_awaddr, 32'h10000);
      chk("stall_awlen", bus.axi_awlen, 63);
      @(negedge clock);
    end
    aw_man = 1;
    finish_line();
    bus.fifo_count = 10'd1023;

    // Error response on the second B, sticky across lines.
    new_frame(0);
    err_idx = b_issued + 1;
    run_line(100);
    chk("err_set", err_flag, 1);
    err_idx = -1;
    run_line(40);
    chk("err_sticky", err_flag, 1);

    // Asynchronous reset in the middle of a W burst.
    start_line(200);
    n = 0;
    while (!bus.axi_wvalid && n < 100) begin @(negedge clock); n++; end
    repeat (5) @(negedge clock);
    chk("midw_wvalid", bus.axi_wvalid, 1);
    @(posedge clock); #3;
    rst = 1;
    #1;
    chk("rst_w_drop", {bus.axi_wvalid, bus.axi_awvalid, busy}, 0);
    chk("rst_err_clear", err_flag, 0);
    chk("rst_pulses", {line_ack, line_done, bus.fifo_rd_en}, 0);
    line_seq = 0;
    repeat (2) @(posedge clock);
    #1;
    rst = 0;
    new_frame(32'h400);
    run_line(20);
    chk("post_rst_err", err_flag, 0);

    // Randomised lines with random handshakes, plus wrap and single-beat cases.
    rdy_rand = 1;
    new_frame(32'h1FFF_FFC0);
    run_line(4);
    run_line(1);
    for (int i = 0; i < 8; i++) begin
      cfg_line_stride = ($urandom & AMASK) & ~29'h1F;
      if (i % 3 == 0) new_frame(($urandom & AMASK) & 32'h1FFF_FFE0);
      run_line($urandom_range(1, 300));
    end
    rdy_rand = 0;
    repeat (5) @(negedge clock);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mm_line_burst_writer.md
Name: mm_line_burst_writer

Overview:
- Parametrised successor to the current frame write path: the AXI4 write master that moves one video line at a time from the stream FIFO into memory.
- Generalises fixed-stride, fixed-threshold addressing: runtime base address, line stride and line length in beats.
- Splits each line into bursts capped by MAX_BURST and by 4 KB boundaries, keeps up to MAX_OUTSTANDING writes in flight, and reports line completion and write errors.
- Sits between the show-ahead stream FIFO read side and the AXI interconnect, in the AXI clock domain.

Parameters:
ASIZE, 29, AXI address width
AXI_DSIZE, 256, AXI data width; bytes per beat BB = AXI_DSIZE/8 (power of 2, 8..1024 bits)
IDSIZE, 4, AXI ID width
ID, 0, constant awid value
BURST_LEN_SIZE, 8, awlen width
MAX_BURST, 64, maximum beats per burst (<= 2^BURST_LEN_SIZE, <= 256)
MAX_OUTSTANDING, 4, maximum bursts issued without a B response
CSIZE, 10, FIFO count width

Ports:
clock  in  1  AXI clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
cfg_base_addr  in  ASIZE  frame base byte address, BB-aligned
cfg_line_stride  in  ASIZE  byte increment between lines, BB-aligned
cfg_line_beats  in  16  beats per line, must be >0
frame_start  in  1  pulse: next line starts at cfg_base_addr
line_req  in  1  level: request to write one line
line_ack  out  1  1-cycle pulse: line_req accepted
line_done  out  1  1-cycle pulse: all B responses for the line received
busy  out  1  high from acceptance until line_done
err_flag  out  1  sticky: any bresp != 0; cleared only by rst
fifo_count  in  CSIZE  FIFO read-side word count
fifo_dout  in  AXI_DSIZE  FIFO show-ahead data
fifo_rd_en  out  1  FIFO pop
axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  IDSIZE/ASIZE/BURST_LEN_SIZE/3/2/1  AW channel
axi_awready  in  1
axi_wdata/wstrb/wlast/wvalid  out  AXI_DSIZE/AXI_DSIZE/8/1/1  W channel
axi_wready  in  1
axi_bready  out  1  tied high
axi_bid/bresp/bvalid  in  IDSIZE/2/1  B channel

Behaviour:
- Reset values: all outputs 0 except axi_bready=1; awid=ID; awsize=log2(BB); awburst=INCR. Line pointer = 0; outstanding count = 0; pending-frame flag = 0.
- wstrb is all ones. wdata = fifo_dout. fifo_rd_en = wvalid & wready.
- IDLE:
  - Apply a pending frame_start, or a frame_start seen this cycle: line_ptr <= cfg_base_addr.
  - If line_req: latch remaining <= cfg_line_beats and addr <= line_ptr; pulse line_ack; busy=1; go to CALC.
- CALC (1 cycle): len = min(remaining, MAX_BURST, (4096 - addr[11:0])/BB).
- WAITDATA: stay until fifo_count >= len and outstanding < MAX_OUTSTANDING; then go to AW.
- AW:
  - awvalid=1; awaddr=addr; awlen=len-1.
  - Hold awvalid and all AW fields stable until awready.
  - On handshake: outstanding+1; go to W.
- W:
  - wvalid=1 continuously; beat counter runs on each wready.
  - wlast on beat len-1.
  - On the last handshake: addr += len*BB; remaining -= len; if remaining==0 go to DRAIN, else go to CALC.
- DRAIN:
  - Wait for outstanding==0.
  - Then pulse line_done; busy=0; line_ptr += cfg_line_stride; go to IDLE.
  - A pending frame_start overrides this line_ptr increment on the next IDLE cycle.
- B channel, every cycle in any state:
  - bvalid decrements outstanding.
  - A simultaneous AW handshake and bvalid leave the count unchanged.
  - bresp != 0 sets err_flag; bid is ignored.
- frame_start while busy: set the pending flag; the current line completes at the old address.
- line_req held high after line_done: the next line is accepted on the IDLE cycle, giving a 1-cycle gap.
- Timing: line_ack is registered, 1 cycle after line_req is sampled in IDLE. The first awvalid appears no earlier than 2 cycles after line_ack.
- Address arithmetic wraps modulo 2^ASIZE, with no error.
- An asserted rst mid-burst aborts immediately: all state is cleared. In-flight AXI transactions are abandoned; the system resets the interconnect together with this block.

Test Plan:
- AXI_DSIZE=256, base=0, line_beats=100, fifo_count=1023, awready/wready=1 -> AW awaddr=0x000 awlen=63, then awaddr=0x800 awlen=35; 64 then 36 W beats with wlast on each burst end; line_done after 2 B responses.
- base=0xF80, line_beats=10 -> bursts at 0xF80 (awlen=3) and 0x1000 (awlen=5); no burst crosses 0x1000.
- stride=0x2000, 3 consecutive lines, frame_start pulsed during line 2 -> lines at 0x0 and 0x2000; line 3 at cfg_base_addr=0x0.
- bvalid held low, line_beats=640, MAX_OUTSTANDING=4 -> exactly 4 AW handshakes, then awvalid stays low; releasing one bvalid -> 5th AW appears.
- fifo_count=10 for 50 cycles with line_beats=64 -> no awvalid; raise count to 64 -> awvalid within 2 cycles; awready stalled 7 cycles -> awaddr/awlen stable throughout.
- bresp=2 on the second B -> err_flag=1 and stays 1 across later lines; rst asserted mid-W -> wvalid/awvalid/busy=0 in the same cycle; err_flag cleared.
